// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port parity RAM.
// Reads are parity-checked on return; parity errors are tallied in a saturating counter.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [1:0]          i_req_valid,
  input  logic [1:0]          i_req_write,
  input  logic [ADDR_W-1:0]   i_req_addr0,
  input  logic [ADDR_W-1:0]   i_req_addr1,
  input  logic [DATA_W-1:0]   i_req_wdata0,
  input  logic [DATA_W-1:0]   i_req_wdata1,
  output logic [1:0]          o_req_gnt,
  output logic [1:0]          o_rsp_valid,
  output logic [DATA_W-1:0]   o_rsp_data,
  output logic                o_rsp_perr,
  output logic [ERRCNT_W-1:0] o_err_cnt,
  output logic                o_mem_write,
  output logic                o_mem_read,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W:0]     i_mem_rdata
);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StCap} state_e;

  localparam logic [ERRCNT_W-1:0] ErrMax = '1;

  state_e r_state;
  logic   r_last;   // last requester served; 1 = req1
  logic   r_owner;  // requester owning the read in flight

  logic [1:0] w_gnt;
  logic       w_sel;
  logic       w_perr;

  // Grant is suppressed during reset so nothing is accepted on a reset edge.
  always_comb begin
    w_gnt = 2'b00;
    if (r_state == StIdle && !i_reset) begin
      if (i_req_valid == 2'b11) begin
        w_gnt = r_last ? 2'b01 : 2'b10;
      end else begin
        w_gnt = i_req_valid;
      end
    end
  end

  assign o_req_gnt = w_gnt;
  assign w_sel     = w_gnt[1];
  assign w_perr    = ^i_mem_rdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      o_rsp_valid <= 2'b00;
      o_rsp_data  <= '0;
      o_rsp_perr  <= 1'b0;
      o_err_cnt   <= '0;
      o_mem_write <= 1'b0;
      o_mem_read  <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_rsp_valid <= 2'b00;
      o_mem_write <= 1'b0;
      o_mem_read  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (|w_gnt) begin
            r_last      <= w_sel;
            r_owner     <= w_sel;
            o_mem_addr  <= w_sel ? i_req_addr1 : i_req_addr0;
            o_mem_wdata <= w_sel ? i_req_wdata1 : i_req_wdata0;
            if (i_req_write[w_sel]) begin
              o_mem_write <= 1'b1;
              r_state     <= StWr;
            end else begin
              o_mem_read <= 1'b1;
              r_state    <= StRd;
            end
          end
        end
        StWr: r_state <= StIdle;
        StRd: r_state <= StCap;
        StCap: begin
          o_rsp_data           <= i_mem_rdata[DATA_W-1:0];
          o_rsp_perr           <= w_perr;
          o_rsp_valid[r_owner] <= 1'b1;
          if (w_perr && o_err_cnt != ErrMax) begin
            o_err_cnt <= o_err_cnt + 1'b1;
          end
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table-driven requests, RAM model with parity, and a response scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv [2];
  logic        rw [2];
  logic [15:0] ra [2];
  logic [7:0]  rd [2];
  logic [1:0]  gnt, rsp_valid;
  logic [7:0]  rsp_data, err_cnt, mwdata;
  logic        rsp_perr, mwrite, mread;
  logic [15:0] maddr;
  logic [8:0]  rdata;

  logic [8:0]  ram [65536];
  logic        pk_en = 1'b0;
  logic [15:0] pk_a  = '0;
  logic [8:0]  pk_v  = '0;

  typedef struct {int r; logic [7:0] d; logic p; int c;} exp_t;
  typedef struct {logic [15:0] a; logic [7:0] d;} wr_t;
  typedef struct {int r; bit wr; logic [15:0] a; logic [7:0] d; logic [7:0] ed; bit ep; bit bad;} vec_t;

  exp_t sb [$];
  wr_t  wq [$];
  int   glog [$];
  int   gcyc [$];
  bit   log_en = 1'b0;
  int   cyc = 0, n_pass = 0, n_tot = 0, n_mw = 0;
  int   exp_err = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .ERRCNT_W(8)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid ({rv[1], rv[0]}),
    .i_req_write ({rw[1], rw[0]}),
    .i_req_addr0 (ra[0]),
    .i_req_addr1 (ra[1]),
    .i_req_wdata0(rd[0]),
    .i_req_wdata1(rd[1]),
    .o_req_gnt   (gnt),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_rsp_perr  (rsp_perr),
    .o_err_cnt   (err_cnt),
    .o_mem_write (mwrite),
    .o_mem_read  (mread),
    .o_mem_addr  (maddr),
    .o_mem_wdata (mwdata),
    .i_mem_rdata (rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: even parity generated on write, synchronous read.
  always @(posedge clk) begin
    if (pk_en) ram[pk_a] <= pk_v;
    else if (mwrite) ram[maddr] <= {^mwdata, mwdata};
    if (mread) rdata <= ram[maddr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: sampled 2ns after each falling edge, away from the active edge.
  always begin
    exp_t e;
    wr_t  w;
    @(negedge clk);
    #2;
    if (rst) begin
      exp_err = 0;
      sb.delete();
      wq.delete();
    end else begin
      if (gnt != 2'b00 && log_en) begin
        glog.push_back(int'(gnt));
        gcyc.push_back(cyc);
      end
      if (mwrite) begin
        n_mw++;
        if (wq.size() == 0) chk("unexpected mem_write", 1, 0);
        else begin
          w = wq.pop_front();
          chk("mem_addr on write", maddr, w.a);
          chk("mem_wdata on write", mwdata, w.d);
        end
      end
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) chk("unexpected rsp_valid", rsp_valid, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_valid owner", rsp_valid, (e.r == 1) ? 2'b10 : 2'b01);
          chk("rsp_data", rsp_data, e.d);
          chk("rsp_perr", rsp_perr, e.p);
          chk("read latency", cyc - e.c, 3);
          if (e.p && exp_err != 255) exp_err++;
          chk("err_cnt", err_cnt, exp_err);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the grant.
  task automatic issue(input int r, input bit wr, input logic [15:0] a, input logic [7:0] d,
                       input logic [7:0] ed, input bit ep);
    bit   got;
    exp_t e;
    wr_t  w;
    got   = 1'b0;
    rv[r] = 1'b1;
    rw[r] = wr;
    ra[r] = a;
    rd[r] = d;
    for (int i = 0; i < 40 && !got; i++) begin
      #2;
      if (gnt[r]) begin
        got = 1'b1;
        if (wr) begin
          w.a = a; w.d = d;
          wq.push_back(w);
        end else begin
          e.r = r; e.d = ed; e.p = ep; e.c = cyc;
          sb.push_back(e);
        end
      end
      @(negedge clk);
    end
    rv[r] = 1'b0;
    if (!got) chk("grant timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (sb.size() != 0 || wq.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("scoreboard drained", sb.size() + wq.size(), 0);
  endtask

  task automatic poke(input logic [15:0] a, input logic [8:0] v);
    pk_en = 1'b1; pk_a = a; pk_v = v;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [11];
    logic [15:0] a6 [6];
    logic [7:0]  d6 [6];
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0;
    end
    tbl[0]  = '{0, 1'b1, 16'h1234, 8'hA5, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{0, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, 1'b0};
    tbl[2]  = '{1, 1'b1, 16'h2000, 8'hA5, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{0, 1'b0, 16'h2000, 8'h00, 8'hA5, 1'b1, 1'b1};
    tbl[4]  = '{1, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0, 1'b0};
    tbl[5]  = '{1, 1'b1, 16'h0010, 8'h3C, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{0, 1'b0, 16'h0010, 8'h00, 8'h3C, 1'b0, 1'b0};
    tbl[7]  = '{0, 1'b1, 16'hFFFF, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1, 1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{1, 1'b1, 16'h0000, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{0, 1'b0, 16'h0000, 8'h00, 8'hFF, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("reset req_gnt", gnt, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset rsp_perr", rsp_perr, 0);
    chk("reset err_cnt", err_cnt, 0);
    chk("reset mem_write", mwrite, 0);
    chk("reset mem_read", mread, 0);
    chk("reset mem_addr", maddr, 0);
    chk("reset mem_wdata", mwdata, 0);
    @(negedge clk);

    // Table: write/readback, bad-parity read, good read after it.
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].bad) begin
        drain();
        poke(tbl[i].a, {~(^tbl[i].ed), tbl[i].ed});
      end
      issue(tbl[i].r, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].ed, tbl[i].ep);
    end
    drain();
    chk("err_cnt after table", err_cnt, 1);
    chk("mem_write pulse count", n_mw, 5);

    // Saturation: 300 bad-parity reads.
    poke(16'h3000, 9'h1A5);
    for (int i = 0; i < 300; i++) issue(i % 2, 1'b0, 16'h3000, 8'h00, 8'hA5, 1'b1);
    drain();
    chk("err_cnt saturated", err_cnt, 8'hFF);

    // Reset during CAP of a bad read: no response, counter cleared.
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 16'h3000;
    #2;
    chk("t5 grant", gnt, 2'b01);
    @(negedge clk);
    rv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("t5 mem_read after reset", mread, 0);
    chk("t5 err_cnt after reset", err_cnt, 0);
    chk("t5 rsp_valid after reset", rsp_valid, 0);
    repeat (4) @(negedge clk);
    issue(1, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0);
    drain();
    chk("t5 err_cnt after recovery", err_cnt, 0);

    // Both requesters continuously valid from reset.
    do_reset();
    log_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 16'h0010, 8'h00, 8'h3C, 1'b0);
      end
    join
    log_en = 1'b0;
    drain();
    chk("t2 grant count", glog.size(), 8);
    for (int i = 0; i < glog.size(); i++) begin
      chk("t2 grant order", glog[i], (i % 2 == 1) ? 2 : 1);
      if (i > 0) chk("t2 grant spacing >= 3", (gcyc[i] - gcyc[i-1]) >= 3, 1);
    end

    // Random writes, read back by the other requester.
    for (int i = 0; i < 6; i++) begin
      a6[i] = {4'(8 + i), 12'($urandom)};
      d6[i] = 8'($urandom);
      issue(i % 2, 1'b1, a6[i], d6[i], 8'h00, 1'b0);
    end
    for (int i = 0; i < 6; i++) issue((i + 1) % 2, 1'b0, a6[i], 8'h00, d6[i], 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
